lc3_regfile_psr: RTL and testbench

LC3_REGFILE_PSR -- requirements
Module: lc3_regfile_psr

---
 rtl/lc3_rf_pkg.sv | 21 ++
 rtl/lc3_rf_scoreboard.sv | 59 +++++
 rtl/lc3_regfile_psr.sv | 84 ++++++++
 tb/tb_lc3_regfile_psr.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_rf_pkg.sv
// Shared types and constants for the LC-3 register file with PSR.
// Optional write-bypass is enabled by defining LC3_RF_BYPASS_EN.
package lc3_rf_pkg;

  localparam int REG_COUNT  = 8;
  localparam int DATA_WIDTH = 16;
  localparam int REG_IDX_W  = $clog2(REG_COUNT);

  typedef logic [REG_IDX_W-1:0]  reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [2:0]            nzp_t;

  localparam nzp_t PSR_RESET = 3'b010;

  function automatic nzp_t nzp_of(input word_t w);
    if (w[DATA_WIDTH-1]) return 3'b100;
    if (w == '0)         return 3'b010;
    return 3'b001;
  endfunction

endpackage

// File: rtl/lc3_rf_scoreboard.sv
// Pending-write scoreboard: pending bits, their popcount and
// the sticky orphan-write flag.
module lc3_rf_scoreboard
  import lc3_rf_pkg::*;
#(
  parameter int NREG = REG_COUNT,
  parameter int IW   = $clog2(NREG),
  parameter int CW   = $clog2(NREG + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en_i,
  input  logic [IW-1:0]   wr_idx_i,
  input  logic            mark_en_i,
  input  logic [IW-1:0]   mark_idx_i,
  output logic [NREG-1:0] pending_o,
  output logic [CW-1:0]   count_o,
  output logic            orphan_o
);

  logic [NREG-1:0] pending_q, pending_d;
  logic [CW-1:0]   count_q, count_d;
  logic            orphan_q, orphan_d;

  // Clear first, then set, so a same-cycle mark wins over the write.
  always_comb begin
    pending_d = pending_q;
    orphan_d  = orphan_q;
    if (wr_en_i) begin
      orphan_d            = orphan_q | ~pending_q[wr_idx_i];
      pending_d[wr_idx_i] = 1'b0;
    end
    if (mark_en_i) pending_d[mark_idx_i] = 1'b1;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NREG; i++) begin
      count_d = count_d + CW'(pending_d[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      count_q   <= '0;
      orphan_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      orphan_q  <= orphan_d;
    end
  end

  assign pending_o = pending_q;
  assign count_o   = count_q;
  assign orphan_o  = orphan_q;

endmodule

// File: rtl/lc3_regfile_psr.sv
// LC-3 register file with condition codes and pending-write scoreboard.
// Define LC3_RF_BYPASS_EN to forward write-back data to the read ports.
module lc3_regfile_psr
  import lc3_rf_pkg::*;
#(
  parameter int REG_COUNT  = lc3_rf_pkg::REG_COUNT,
  parameter int DATA_WIDTH = lc3_rf_pkg::DATA_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable_writeback,
  input  logic [$clog2(REG_COUNT)-1:0] dr,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  input  logic                         mark_valid,
  input  logic [$clog2(REG_COUNT)-1:0] mark_dr,
  input  logic [$clog2(REG_COUNT)-1:0] sr1,
  input  logic [$clog2(REG_COUNT)-1:0] sr2,
  output logic [DATA_WIDTH-1:0]        vsr1,
  output logic [DATA_WIDTH-1:0]        vsr2,
  output logic [2:0]                   psr,
  output logic                         busy_sr1,
  output logic                         busy_sr2,
  output logic [$clog2(REG_COUNT+1)-1:0] pend_count,
  output logic                         wb_orphan
);

  localparam int IW = $clog2(REG_COUNT);
  localparam int CW = $clog2(REG_COUNT + 1);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  nzp_t                  psr_q, psr_d;
  logic [REG_COUNT-1:0]  pending;
  logic                  byp1, byp2;

  always_comb begin
    psr_d = psr_q;
    if (enable_writeback) begin
      if (wb_data[DATA_WIDTH-1]) psr_d = 3'b100;
      else if (wb_data == '0)    psr_d = 3'b010;
      else                       psr_d = 3'b001;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      psr_q <= PSR_RESET;
    end else begin
      if (enable_writeback) regs_q[dr] <= wb_data;
      psr_q <= psr_d;
    end
  end

  lc3_rf_scoreboard #(
    .NREG (REG_COUNT),
    .IW   (IW),
    .CW   (CW)
  ) u_sb (
    .clock      (clock),
    .reset      (reset),
    .wr_en_i    (enable_writeback),
    .wr_idx_i   (dr),
    .mark_en_i  (mark_valid),
    .mark_idx_i (mark_dr),
    .pending_o  (pending),
    .count_o    (pend_count),
    .orphan_o   (wb_orphan)
  );

`ifdef LC3_RF_BYPASS_EN
  assign byp1 = enable_writeback && (sr1 == dr);
  assign byp2 = enable_writeback && (sr2 == dr);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign vsr1     = byp1 ? wb_data : regs_q[sr1];
  assign vsr2     = byp2 ? wb_data : regs_q[sr2];
  assign busy_sr1 = pending[sr1] & ~byp1;
  assign busy_sr2 = pending[sr2] & ~byp2;
  assign psr      = psr_q;

endmodule

// File: tb/tb_lc3_regfile_psr.sv
// Self-checking bench for lc3_regfile_psr (directed + random vs. model).
// Follows LC3_RF_BYPASS_EN to select the expected read-port behaviour.
module tb_lc3_regfile_psr;

  logic        clock;
  logic        reset;
  logic        enable_writeback;
  logic [2:0]  dr;
  logic [15:0] wb_data;
  logic        mark_valid;
  logic [2:0]  mark_dr;
  logic [2:0]  sr1, sr2;
  logic [15:0] vsr1, vsr2;
  logic [2:0]  psr;
  logic        busy_sr1, busy_sr2;
  logic [3:0]  pend_count;
  logic        wb_orphan;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_regs [8];
  logic [2:0]  m_psr;
  bit          m_pend [8];
  bit          m_orph;

  lc3_regfile_psr dut (
    .clock            (clock),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .dr               (dr),
    .wb_data          (wb_data),
    .mark_valid       (mark_valid),
    .mark_dr          (mark_dr),
    .sr1              (sr1),
    .sr2              (sr2),
    .vsr1             (vsr1),
    .vsr2             (vsr2),
    .psr              (psr),
    .busy_sr1         (busy_sr1),
    .busy_sr2         (busy_sr2),
    .pend_count       (pend_count),
    .wb_orphan        (wb_orphan)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit byp(input logic [2:0] s);
`ifdef LC3_RF_BYPASS_EN
    return enable_writeback && (s == dr);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] exp_v(input logic [2:0] s);
    return byp(s) ? wb_data : m_regs[s];
  endfunction

  function automatic logic exp_busy(input logic [2:0] s);
    return m_pend[s] && !byp(s);
  endfunction

  function automatic logic [15:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < 8; i++) if (m_pend[i]) n++;
    return 16'(n);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 16'h0000;
      m_pend[i] = 1'b0;
    end
    m_psr  = 3'b010;
    m_orph = 1'b0;
  endtask

  task automatic model_edge();
    if (enable_writeback) begin
      m_regs[dr] = wb_data;
      if (wb_data[15])          m_psr = 3'b100;
      else if (wb_data == 16'h0) m_psr = 3'b010;
      else                       m_psr = 3'b001;
      if (!m_pend[dr]) m_orph = 1'b1;
      m_pend[dr] = 1'b0;
    end
    if (mark_valid) m_pend[mark_dr] = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".vsr1"}, vsr1, exp_v(sr1));
    chk({tag, ".vsr2"}, vsr2, exp_v(sr2));
    chk({tag, ".psr"}, 16'(psr), 16'(m_psr));
    chk({tag, ".busy1"}, 16'(busy_sr1), 16'(exp_busy(sr1)));
    chk({tag, ".busy2"}, 16'(busy_sr2), 16'(exp_busy(sr2)));
    chk({tag, ".cnt"}, 16'(pend_count), exp_cnt());
    chk({tag, ".orph"}, 16'(wb_orphan), 16'(m_orph));
  endtask

  task automatic idle();
    enable_writeback = 1'b0;
    mark_valid       = 1'b0;
  endtask

  // Called at edge+1; returns at the following edge+1.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all("rst");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    enable_writeback = 1'b0;
    dr = '0; wb_data = '0;
    mark_valid = 1'b0; mark_dr = '0;
    sr1 = '0; sr2 = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      #1;
      chk("rst.r", vsr1, 16'h0000);
      check_all("rst.all");
    end
    chk("rst.psr", 16'(psr), 16'h0002);
    chk("rst.cnt", 16'(pend_count), 16'h0000);
    chk("rst.orph", 16'(wb_orphan), 16'h0000);

    sr1 = 3'd3; sr2 = 3'd0;
    enable_writeback = 1'b1; dr = 3'd3; wb_data = 16'h8001;
    tick("cc1"); idle(); #1;
    chk("cc1.psr", 16'(psr), 16'h0004);
    chk("cc1.v", vsr1, 16'h8001);
    enable_writeback = 1'b1; wb_data = 16'h0000;
    tick("cc2"); idle(); #1;
    chk("cc2.psr", 16'(psr), 16'h0002);
    chk("cc2.v", vsr1, 16'h0000);
    enable_writeback = 1'b1; wb_data = 16'h7FFF;
    tick("cc3"); idle(); #1;
    chk("cc3.psr", 16'(psr), 16'h0001);
    chk("cc3.v", vsr1, 16'h7FFF);
    tick("hold");
    chk("hold.psr", 16'(psr), 16'h0001);

    do_reset();
    sr1 = 3'd2;
    mark_valid = 1'b1; mark_dr = 3'd2;
    tick("mk2");
    mark_dr = 3'd5;
    tick("mk5"); idle(); #1;
    chk("sb.cnt2", 16'(pend_count), 16'd2);
    chk("sb.busy", 16'(busy_sr1), 16'd1);
    mark_valid = 1'b1; mark_dr = 3'd5;
    tick("remark"); idle(); #1;
    chk("sb.remark", 16'(pend_count), 16'd2);
    enable_writeback = 1'b1; dr = 3'd2; wb_data = 16'h0042;
    tick("wr2"); idle(); #1;
    chk("sb.cnt1", 16'(pend_count), 16'd1);
    chk("sb.nbusy", 16'(busy_sr1), 16'd0);
    chk("sb.norph", 16'(wb_orphan), 16'd0);

    do_reset();
    sr1 = 3'd4;
    mark_valid = 1'b1; mark_dr = 3'd4;
    enable_writeback = 1'b1; dr = 3'd4; wb_data = 16'h1111;
    tick("sim"); idle(); #1;
    chk("sim.busy", 16'(busy_sr1), 16'd1);
    chk("sim.cnt", 16'(pend_count), 16'd1);
    chk("sim.orph", 16'(wb_orphan), 16'd1);

    sr2 = 3'd1;
    enable_writeback = 1'b1; dr = 3'd1; wb_data = 16'hBEEF;
    #1;
`ifdef LC3_RF_BYPASS_EN
    chk("byp.in", vsr2, 16'hBEEF);
`else
    chk("byp.in", vsr2, m_regs[1]);
`endif
    check_all("byp.pre");
    tick("byp"); idle(); #1;
    chk("byp.post", vsr2, 16'hBEEF);

    do_reset();
    mark_valid = 1'b1; mark_dr = 3'd0;
    tick("m0");
    mark_dr = 3'd1;
    tick("m1");
    mark_dr = 3'd2;
    mark_valid = 1'b1;
    enable_writeback = 1'b1; dr = 3'd6; wb_data = 16'h1234;
    tick("m2"); idle();
    sr1 = 3'd6;
    #1;
    chk("mid.cnt", 16'(pend_count), 16'd3);
    chk("mid.r6", vsr1, 16'h1234);
    enable_writeback = 1'b1; dr = 3'd6; wb_data = 16'hFFFF;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid.r6z", vsr1, 16'h0000);
    chk("mid.cnt0", 16'(pend_count), 16'd0);
    chk("mid.psr", 16'(psr), 16'h0002);
    check_all("mid");
    @(posedge clock);
    #1;
    check_all("mid.hold");
    @(negedge clock);
    reset = 1'b0;
    idle();
    @(posedge clock);
    #1;

    for (int n = 0; n < 300; n++) begin
      enable_writeback = 1'($urandom_range(0, 1));
      mark_valid       = 1'($urandom_range(0, 1));
      dr      = 3'($urandom_range(0, 7));
      mark_dr = 3'($urandom_range(0, 7));
      sr1     = 3'($urandom_range(0, 7));
      sr2     = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       wb_data = 16'h0000;
        1:       wb_data = 16'h8000 | 16'($urandom);
        default: wb_data = 16'($urandom);
      endcase
      #1;
      check_all("rnd.c");
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
